cordic_pipe_engine: RTL and testbench

//  Parametrised, back-pressured CORDIC pipeline; successor to the fixed rotation-only stage chain.
//  Per-transaction mode: rotation (rotate x,y by phi) or vectoring (magnitude/angle of x,y).

---
 rtl/cordic_pkg.sv | 42 ++++
 rtl/cordic_stage.sv | 50 +++++
 rtl/cordic_pipe_engine.sv | 167 ++++++++++++++++
 tb/tb_cordic_pipe_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC pipeline: angle table, gain inverse, stage payload.
// Internal x/y/phi containers are wide enough for any DATA_WIDTH <= 32 / PHI_WIDTH <= 33.
package cordic_pkg;

    localparam int CORDIC_XW = 34;
    localparam int CORDIC_PW = 34;
    localparam int LUT_FRAC  = 12;

    // atan(2^-i) in degrees, Q.12, round to nearest
    localparam int ATAN_LUT [16] = '{
        184320, 108810, 57492, 29184, 14649, 7331, 3667, 1833,
        917, 458, 229, 115, 57, 29, 14, 7
    };

    localparam int CORDIC_KINV = 2487;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } mode_e;

    typedef struct packed {
        logic                        valid;
        mode_e                       mode;
        logic signed [CORDIC_XW-1:0] x;
        logic signed [CORDIC_XW-1:0] y;
        logic signed [CORDIC_PW-1:0] phi;
    } stage_t;

    function automatic logic signed [CORDIC_PW-1:0] atan_lut(input int iter, input int frac);
        logic signed [CORDIC_PW-1:0] v;
        v = CORDIC_PW'(ATAN_LUT[iter]);
        if (frac >= LUT_FRAC) return v <<< (frac - LUT_FRAC);
        return v >>> (LUT_FRAC - frac);
    endfunction

    function automatic int kinv_q(input int frac);
        if (frac >= LUT_FRAC) return CORDIC_KINV <<< (frac - LUT_FRAC);
        return CORDIC_KINV >>> (LUT_FRAC - frac);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation register for iteration ITER; loads its predecessor when en is high.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int ITER      = 0,
    parameter int FRAC_BITS = 12
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  stage_t prev,
    output stage_t cur
);

    localparam logic signed [CORDIC_PW-1:0] ATAN = atan_lut(ITER, FRAC_BITS);

    logic signed [CORDIC_XW-1:0] px, py, x_sh, y_sh;
    logic signed [CORDIC_PW-1:0] pphi;
    logic                        rot_pos;
    stage_t                      nxt;

    always_comb begin
        px      = prev.x;
        py      = prev.y;
        pphi    = prev.phi;
        x_sh    = px >>> ITER;
        y_sh    = py >>> ITER;
        // rotation drives phi toward 0, vectoring drives y toward 0
        rot_pos = (prev.mode == MODE_ROT) ? ~pphi[CORDIC_PW-1] : py[CORDIC_XW-1];
        nxt     = prev;
        if (rot_pos) begin
            nxt.x   = px - y_sh;
            nxt.y   = py + x_sh;
            nxt.phi = pphi - ATAN;
        end else begin
            nxt.x   = px + y_sh;
            nxt.y   = py - x_sh;
            nxt.phi = pphi + ATAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else if (en) begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/cordic_pipe_engine.sv
// Back-pressured CORDIC pipeline: quadrant pre-rotation, STAGES micro-rotations, saturated outputs.
// Define CORDIC_GAIN_COMP_EN to add an output stage that removes the CORDIC gain (latency +1).
module cordic_pipe_engine
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int PHI_WIDTH  = 22,
    parameter int FRAC_BITS  = 12,
    parameter int STAGES     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [PHI_WIDTH-1:0]  in_phi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [PHI_WIDTH-1:0]  out_phi,
    output logic                  busy
);

    localparam logic signed [CORDIC_PW-1:0] PHI90   = CORDIC_PW'(90) <<< FRAC_BITS;
    localparam logic signed [CORDIC_XW-1:0] SAT_MAX = (CORDIC_XW'(1) <<< (DATA_WIDTH-1)) - CORDIC_XW'(1);
    localparam logic signed [CORDIC_XW-1:0] SAT_MIN = -SAT_MAX - CORDIC_XW'(1);

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [CORDIC_XW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    logic signed [CORDIC_XW-1:0] ix, iy;
    logic signed [CORDIC_PW-1:0] iphi;
    stage_t                      pre, st0;
    stage_t                      pipe [0:STAGES];
    logic [STAGES:0]             en;
    logic                        tail_ready;
    logic                        busy_c;

    assign ix   = {{(CORDIC_XW-DATA_WIDTH){in_x[DATA_WIDTH-1]}}, in_x};
    assign iy   = {{(CORDIC_XW-DATA_WIDTH){in_y[DATA_WIDTH-1]}}, in_y};
    assign iphi = {{(CORDIC_PW-PHI_WIDTH){in_phi[PHI_WIDTH-1]}}, in_phi};

    always_comb begin
        pre       = '0;
        pre.valid = in_valid;
        pre.mode  = mode_e'(in_mode);
        pre.x     = ix;
        pre.y     = iy;
        if (in_mode == MODE_ROT) begin
            pre.phi = iphi;
            if (iphi > PHI90) begin
                pre.x   = -iy;
                pre.y   = ix;
                pre.phi = iphi - PHI90;
            end else if (iphi < -PHI90) begin
                pre.x   = iy;
                pre.y   = -ix;
                pre.phi = iphi + PHI90;
            end
        end else if (ix[CORDIC_XW-1] && !iy[CORDIC_XW-1]) begin
            pre.x   = iy;
            pre.y   = -ix;
            pre.phi = PHI90;
        end else if (ix[CORDIC_XW-1]) begin
            pre.x   = -iy;
            pre.y   = ix;
            pre.phi = -PHI90;
        end
    end

    // A stage may load when it is empty or when everything downstream of it can move.
    always_comb begin : advance_chain
        logic acc;
        en  = '0;
        acc = tail_ready;
        for (int k = STAGES; k >= 0; k--) begin
            acc   = acc | ~pipe[k].valid;
            en[k] = acc;
        end
    end

    assign in_ready = en[0];
    assign pipe[0]  = st0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0 <= '0;
        end else if (en[0]) begin
            st0 <= pre;
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        cordic_stage #(
            .ITER      (k - 1),
            .FRAC_BITS (FRAC_BITS)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en[k]),
            .prev  (pipe[k-1]),
            .cur   (pipe[k])
        );
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PRODW = CORDIC_XW + 18;
    localparam logic signed [PRODW-1:0] KINV = PRODW'(kinv_q(FRAC_BITS));
    localparam logic signed [PRODW-1:0] HALF = PRODW'(1) <<< (FRAC_BITS - 1);

    function automatic logic signed [CORDIC_XW-1:0] gain_comp(input logic signed [CORDIC_XW-1:0] v);
        logic signed [PRODW-1:0] p;
        p = PRODW'(v) * KINV + HALF;
        p = p >>> FRAC_BITS;
        return p[CORDIC_XW-1:0];
    endfunction

    stage_t comp_r;

    assign tail_ready = ~comp_r.valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_r <= '0;
        end else if (tail_ready) begin
            comp_r.valid <= pipe[STAGES].valid;
            comp_r.mode  <= pipe[STAGES].mode;
            comp_r.x     <= gain_comp(pipe[STAGES].x);
            comp_r.y     <= gain_comp(pipe[STAGES].y);
            comp_r.phi   <= pipe[STAGES].phi;
        end
    end

    assign out_valid = comp_r.valid;
    assign out_mode  = comp_r.mode;
    assign out_x     = sat(comp_r.x);
    assign out_y     = sat(comp_r.y);
    assign out_phi   = comp_r.phi[PHI_WIDTH-1:0];

    always_comb begin
        busy_c = comp_r.valid;
        for (int k = 0; k <= STAGES; k++) busy_c = busy_c | pipe[k].valid;
    end
`else
    assign tail_ready = out_ready;
    assign out_valid  = pipe[STAGES].valid;
    assign out_mode   = pipe[STAGES].mode;
    assign out_x      = sat(pipe[STAGES].x);
    assign out_y      = sat(pipe[STAGES].y);
    assign out_phi    = pipe[STAGES].phi[PHI_WIDTH-1:0];

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k <= STAGES; k++) busy_c = busy_c | pipe[k].valid;
    end
`endif

    assign busy = busy_c;

endmodule

// File: tb/tb_cordic_pipe_engine.sv
// Self-checking bench for cordic_pipe_engine: directed vectors plus randomized traffic
// checked against an iterative arithmetic reference model and a transaction queue.
module tb_cordic_pipe_engine;

    localparam int DW  = 20;
    localparam int PHW = 22;
    localparam int FB  = 12;
    localparam int S   = 12;
    localparam int ONE = 1 << FB;
    localparam int XMAX = (1 << (DW-1)) - 1;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = S + 2;
    localparam bit COMP = 1'b1;
`else
    localparam int LAT  = S + 1;
    localparam bit COMP = 1'b0;
`endif
    localparam real DEG = 3.14159265358979 / 180.0;

    logic            clk, rst_n;
    logic            in_valid, in_ready, in_mode;
    logic [DW-1:0]   in_x, in_y, out_x, out_y;
    logic [PHW-1:0]  in_phi, out_phi;
    logic            out_valid, out_ready, out_mode, busy;

    cordic_pipe_engine #(
        .DATA_WIDTH (DW),
        .PHI_WIDTH  (PHW),
        .FRAC_BITS  (FB),
        .STAGES     (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_phi    (in_phi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_phi   (out_phi),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int x;
        int y;
        int phi;
        int cyc;
    } txn_t;

    txn_t q[$];
    int   checks = 0, errors = 0, cyc = 0, n_out = 0;
    int   atan_q [16];
    real  k_gain, kc;
    bit   cur_m, accepted, check_lat, bp_on, saw_block, stalled;
    int   cur_x, cur_y, cur_phi, t0, last_x, last_y, last_phi, sent, n0;
    logic [DW-1:0]  hx, hy;
    logic [PHW-1:0] hphi;
    logic           hmode;

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sphi(input logic [PHW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat(input int v);
        if (v > XMAX) return XMAX;
        if (v < -XMAX - 1) return -XMAX - 1;
        return v;
    endfunction

    function automatic int rand_xy();
        return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW-1));
    endfunction

    function automatic int rand_phi();
        return int'($urandom_range(0, 2 * 180 * ONE)) - 180 * ONE;
    endfunction

    // Reference: quadrant fold, then STAGES sequential shift-add rotations on plain integers.
    function automatic void model(input bit m, input int xi, input int yi, input int pi,
                                  output int ox, output int oy, output int op);
        int  x, y, p, t, dx, dy;
        bit  d;
        int  p90;
        p90 = 90 * ONE;
        x = xi; y = yi; p = m ? 0 : pi;
        if (!m) begin
            if (p > p90)       begin t = x; x = -y; y = t;  p -= p90; end
            else if (p < -p90) begin t = x; x = y;  y = -t; p += p90; end
        end else begin
            if (x < 0 && y >= 0) begin t = x; x = y;  y = -t; p = p90;  end
            else if (x < 0)      begin t = x; x = -y; y = t;  p = -p90; end
        end
        for (int i = 0; i < S; i++) begin
            d  = m ? (y < 0) : (p >= 0);
            dx = y >>> i;
            dy = x >>> i;
            if (d) begin x -= dx; y += dy; p -= atan_q[i]; end
            else   begin x += dx; y -= dy; p += atan_q[i]; end
        end
        if (COMP) begin
            x = int'((longint'(x) * 2487 + 2048) >>> 12);
            y = int'((longint'(y) * 2487 + 2048) >>> 12);
        end
        ox = sat(x);
        oy = sat(y);
        op = p;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic near(input string tag, input int obs, input real exp, input int tol);
        int e, d;
        e = int'(exp);
        d = obs - e;
        if (d < 0) d = -d;
        checks++;
        assert (d <= tol) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d +-%0d", tag, obs, e, tol);
        end
    endtask

    task automatic step();
        txn_t t, e;
        int   ox, oy, op;
        @(negedge clk);
        accepted = 1'b0;
        if (stalled) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_x", sx(out_x), sx(hx));
            chk("stall_y", sx(out_y), sx(hy));
            chk("stall_phi", sphi(out_phi), sphi(hphi));
            chk("stall_mode", int'(out_mode), int'(hmode));
        end
        if (in_valid && in_ready) begin
            t = '{cur_m, cur_x, cur_y, cur_phi, cyc};
            q.push_back(t);
            accepted = 1'b1;
        end
        if (!in_ready) saw_block = 1'b1;
        if (out_valid && out_ready) begin
            chk("output_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                model(e.m, e.x, e.y, e.phi, ox, oy, op);
                chk("res_x", sx(out_x), ox);
                chk("res_y", sx(out_y), oy);
                chk("res_phi", sphi(out_phi), op);
                chk("res_mode", int'(out_mode), int'(e.m));
                if (check_lat) chk("latency", cyc - e.cyc, LAT);
                last_x = sx(out_x); last_y = sx(out_y); last_phi = sphi(out_phi);
                n_out++;
            end
        end
        stalled = out_valid && !out_ready;
        hx = out_x; hy = out_y; hphi = out_phi; hmode = out_mode;
        @(posedge clk);
        #1;
        cyc++;
        if (bp_on) out_ready = !((cyc - t0) >= 10 && (cyc - t0) <= 14);
    endtask

    task automatic drive(input bit m, input int x, input int y, input int phi);
        cur_m = m; cur_x = x; cur_y = y; cur_phi = phi;
        in_mode  = m;
        in_x     = x[DW-1:0];
        in_y     = y[DW-1:0];
        in_phi   = phi[PHW-1:0];
        in_valid = 1'b1;
    endtask

    task automatic send(input bit m, input int x, input int y, input int phi);
        drive(m, x, y, phi);
        for (int i = 0; i < 100; i++) begin
            step();
            if (accepted) break;
        end
        chk("accepted", int'(accepted), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        k_gain = 1.0;
        for (int i = 0; i < 16; i++) begin
            atan_q[i] = int'($atan(2.0 ** (-i)) / DEG * real'(ONE));
            if (i < S) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));
        end
        kc = COMP ? 1.0 : k_gain;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_phi = '0;
        out_ready = 1'b1; check_lat = 1'b0; bp_on = 1'b0; saw_block = 1'b0; stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_x", sx(out_x), 0);
        chk("rst_out_phi", sphi(out_phi), 0);
        chk("rst_out_mode", int'(out_mode), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        // 1: rotation (3,3) by 5 degrees with latency
        check_lat = 1'b1;
        send(1'b0, 3 * ONE, 3 * ONE, 5 * ONE);
        drain();
        check_lat = 1'b0;
        near("t1_x", last_x, kc * (3.0 * $cos(5.0 * DEG) - 3.0 * $sin(5.0 * DEG)) * ONE, 64);
        near("t1_y", last_y, kc * (3.0 * $sin(5.0 * DEG) + 3.0 * $cos(5.0 * DEG)) * ONE, 64);
        near("t1_phi", last_phi, 0.0, 200);

        // 2: vectoring (3,4)
        send(1'b1, 3 * ONE, 4 * ONE, 7 * ONE);
        drain();
        near("t2_x", last_x, kc * 5.0 * ONE, 64);
        near("t2_y", last_y, 0.0, 64);
        near("t2_phi", last_phi, $atan2(4.0, 3.0) / DEG * ONE, 200);

        // 3: quadrant handling, both modes
        send(1'b0, ONE, 0, 135 * ONE);
        drain();
        near("t3_rot_x", last_x, -kc * $sqrt(0.5) * ONE, 64);
        near("t3_rot_y", last_y, kc * $sqrt(0.5) * ONE, 64);
        send(1'b1, -ONE, -ONE, 0);
        drain();
        near("t3_vec_phi", last_phi, -135.0 * ONE, 200);
        near("t3_vec_x", last_x, kc * $sqrt(2.0) * ONE, 64);

        // 4: 40 back-to-back inputs with a 5-cycle downstream stall
        n0 = n_out; saw_block = 1'b0; t0 = cyc; bp_on = 1'b1;
        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), rand_xy(), rand_xy(), rand_phi());
        bp_on = 1'b0;
        drain();
        chk("bp_count", n_out - n0, 40);
        chk("bp_in_ready_dropped", int'(saw_block), 1);

        // 5: saturation
        send(1'b0, XMAX, XMAX, 45 * ONE);
        drain();
        chk("sat_y", last_y, COMP ? sat(int'((longint'(XMAX) * 2 * 2487) >>> 12)) : XMAX);
        send(1'b0, XMAX, 0, 0);
        drain();
        if (!COMP) chk("sat_x", last_x, XMAX);

        // 6: reset mid-stream
        for (int i = 0; i < 6; i++) send(1'b0, rand_xy(), rand_xy(), rand_phi());
        chk("busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_x", sx(out_x), 0);
        q.delete();
        stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        send(1'b1, 2 * ONE, -ONE, 0);
        drain();
        for (int i = 0; i < 20; i++) step();
        chk("post_rst_results", n_out - n0, 1);

        // 7: randomized mixed traffic with random backpressure
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 4000 && sent < 200; c++) begin
            if (!(in_valid && !accepted)) begin
                if ($urandom_range(0, 3) != 0) drive(1'($urandom_range(0, 1)), rand_xy(), rand_xy(), rand_phi());
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (accepted) sent++;
        end
        in_valid = 1'b0;
        chk("random_sent", sent, 200);
        drain();
        chk("final_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
